// File: rtl/perceptron_update_sched.sv
`default_nettype none
// ============================================================================
// Module  : perceptron_update_sched
// Brief   : Queues perceptron training requests and rewrites weights one at a
//           time through a shared single-port weight memory.
// Revision: 1.0 - initial release
// ============================================================================
module perceptron_update_sched #(
    parameter int PERCEPTRON_NUMBER = 64,
    parameter int HISTORY_SIZE      = 16,
    parameter int WIDTH             = 8,
    parameter int FIFO_DEPTH        = 4,
    parameter int THRESHOLD         = 44
) (
    input  logic                                                       clk,
    input  logic                                                       rst,
    input  logic                                                       req_valid,
    output logic                                                       req_ready,
    input  logic [$clog2(PERCEPTRON_NUMBER)-1:0]                       req_index,
    input  logic [HISTORY_SIZE-1:0]                                    req_history,
    input  logic                                                       req_outcome,
    input  logic                                                       req_prediction,
    input  logic signed [WIDTH+$clog2(HISTORY_SIZE+1):0]               req_output,
    input  logic                                                       lookup_req,
    output logic                                                       mem_rd_en,
    output logic                                                       mem_wr_en,
    output logic [$clog2(PERCEPTRON_NUMBER)+$clog2(HISTORY_SIZE+1)-1:0] mem_addr,
    output logic signed [WIDTH-1:0]                                    mem_wdata,
    input  logic signed [WIDTH-1:0]                                    mem_rdata,
    output logic                                                       busy,
    output logic                                                       done,
    output logic [15:0]                                                update_count,
    output logic [15:0]                                                skip_count
);

    localparam int c_wn = HISTORY_SIZE + 1;
    localparam int c_kw = $clog2(c_wn);
    localparam int c_pw = $clog2(PERCEPTRON_NUMBER);
    localparam int c_fw = $clog2(FIFO_DEPTH);
    localparam int c_ow = WIDTH + c_kw + 1;

    localparam logic signed [c_ow-1:0] c_thr_pos = c_ow'(THRESHOLD);
    localparam logic signed [c_ow-1:0] c_thr_neg = -c_thr_pos;
    localparam logic [c_kw-1:0]        c_k_last  = c_kw'(c_wn - 1);
    localparam logic [c_fw:0]          c_full    = (c_fw+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CAP  = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t                   r_state;
    logic [c_pw-1:0]          r_p;
    logic [HISTORY_SIZE-1:0]  r_hist;
    logic                     r_taken;
    logic [c_kw-1:0]          r_k;
    logic signed [WIDTH-1:0]  r_wnew;

    logic [c_pw-1:0]          r_fifo_idx  [FIFO_DEPTH];
    logic [HISTORY_SIZE-1:0]  r_fifo_hist [FIFO_DEPTH];
    logic                     r_fifo_tk   [FIFO_DEPTH];
    logic [c_fw-1:0]          r_wr_ptr;
    logic [c_fw-1:0]          r_rd_ptr;
    logic [c_fw:0]            r_count;

    logic                     w_in_band;
    logic                     w_train;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_skip;
    logic                     w_pop;
    logic [c_wn-1:0]          w_x_vec;
    logic                     w_inc;
    logic signed [WIDTH:0]    w_delta;
    logic signed [WIDTH:0]    w_sum;
    logic signed [WIDTH-1:0]  w_new;

    // Confident, correct predictions carry no information and are dropped.
    assign w_in_band = (req_output <= c_thr_pos) && (req_output >= c_thr_neg);
    assign w_train   = (req_prediction != req_outcome) || w_in_band;
    assign req_ready = (r_count != c_full);
    assign w_accept  = req_valid && req_ready;
    assign w_push    = w_accept && w_train;
    assign w_skip    = w_accept && !w_train;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);

    // Bit 0 is the always-on bias input; bit k carries history[k-1].
    assign w_x_vec = {r_hist, 1'b1};
    assign w_inc   = (w_x_vec[r_k] == r_taken);
    assign w_delta = w_inc ? (WIDTH+1)'(1) : '1;
    assign w_sum   = {mem_rdata[WIDTH-1], mem_rdata} + w_delta;
    assign w_new   = (w_sum[WIDTH] != w_sum[WIDTH-1])
                   ? {w_sum[WIDTH], {(WIDTH-1){~w_sum[WIDTH]}}}
                   : w_sum[WIDTH-1:0];

    assign busy      = (r_state != S_IDLE);
    assign mem_rd_en = (r_state == S_RD) && !lookup_req;
    assign mem_wr_en = (r_state == S_WR) && !lookup_req;
    assign mem_addr  = (mem_rd_en || mem_wr_en) ? {r_p, r_k} : '0;
    assign mem_wdata = mem_wr_en ? r_wnew : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wr_ptr]  <= req_index;
            r_fifo_hist[r_wr_ptr] <= req_history;
            r_fifo_tk[r_wr_ptr]   <= req_outcome;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            skip_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_skip) begin
                skip_count <= skip_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_p          <= '0;
            r_hist       <= '0;
            r_taken      <= 1'b0;
            r_k          <= '0;
            r_wnew       <= '0;
            done         <= 1'b0;
            update_count <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_p     <= r_fifo_idx[r_rd_ptr];
                        r_hist  <= r_fifo_hist[r_rd_ptr];
                        r_taken <= r_fifo_tk[r_rd_ptr];
                        r_k     <= '0;
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    if (!lookup_req) begin
                        r_state <= S_CAP;
                    end
                end
                S_CAP: begin
                    r_wnew  <= w_new;
                    r_state <= S_WR;
                end
                S_WR: begin
                    if (!lookup_req) begin
                        if (r_k == c_k_last) begin
                            done         <= 1'b1;
                            update_count <= update_count + 16'd1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_k     <= r_k + 1'b1;
                            r_state <= S_RD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_perceptron_update_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_perceptron_update_sched
// Brief   : Directed table-driven bench with a behavioural weight memory.
// Revision: 1.0 - initial release
// ============================================================================
module tb_perceptron_update_sched;

    localparam int PN = 64, HS = 16, WD = 8, FD = 4, TH = 44;
    localparam int KW = 5, PW = 6, OW = WD + KW + 1, AW = PW + KW;

    logic                  clk, rst;
    logic                  req_valid, req_ready;
    logic [PW-1:0]         req_index;
    logic [HS-1:0]         req_history;
    logic                  req_outcome, req_prediction;
    logic signed [OW-1:0]  req_output;
    logic                  lookup_req;
    logic                  mem_rd_en, mem_wr_en;
    logic [AW-1:0]         mem_addr;
    logic signed [WD-1:0]  mem_wdata, mem_rdata;
    logic                  busy, done;
    logic [15:0]           update_count, skip_count;

    perceptron_update_sched #(
        .PERCEPTRON_NUMBER(PN), .HISTORY_SIZE(HS), .WIDTH(WD),
        .FIFO_DEPTH(FD), .THRESHOLD(TH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_history(req_history),
        .req_outcome(req_outcome), .req_prediction(req_prediction),
        .req_output(req_output), .lookup_req(lookup_req),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done),
        .update_count(update_count), .skip_count(skip_count)
    );

    always #5 clk = ~clk;

    // Behavioural weight memory: one-cycle read latency, plus bus protocol tally.
    logic signed [WD-1:0] mem [0:(1<<AW)-1];
    logic                 pl_en, pl_clr;
    logic [AW-1:0]        pl_addr;
    logic signed [WD-1:0] pl_data;
    int                   wr_cnt, rd_cnt, viol;
    int                   order_q[$];

    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
        if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr];
            rd_cnt    <= rd_cnt + 1;
        end
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
            if (mem_addr[KW-1:0] == '0) order_q.push_back(int'(mem_addr[AW-1:KW]));
        end
        if ((mem_rd_en && mem_wr_en) || ((mem_rd_en || mem_wr_en) && lookup_req))
            viol <= viol + 1;
    end

    int errors, checks;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int wa(input int p, input int k);
        return p * 32 + k;
    endfunction

    task automatic preload(input int a, input int v);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a[AW-1:0]; pl_data = v[WD-1:0];
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic send(input logic [PW-1:0] idx, input logic [HS-1:0] hist,
                        input logic oc, input logic pr, input int out);
        @(negedge clk);
        req_index = idx; req_history = hist; req_outcome = oc;
        req_prediction = pr; req_output = out[OW-1:0]; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic push(input logic [PW-1:0] idx, input logic oc);
        int c;
        c = 0;
        req_index = idx; req_history = 16'hA5A5; req_outcome = oc;
        req_prediction = ~oc; req_output = '0; req_valid = 1'b1;
        while (!req_ready && c < 400) begin
            @(negedge clk);
            c++;
        end
        if (c >= 400) check("push_timeout", c, 0);
        @(negedge clk);
    endtask

    task automatic wait_done(input int start, output int lat);
        int c;
        c = start;
        while (!done && c < 400) begin
            @(negedge clk);
            c++;
        end
        lat = c;
        if (!done) check("done_timeout", c, -1);
    endtask

    typedef struct {
        logic [PW-1:0] idx;
        logic [HS-1:0] hist;
        logic          oc;
        logic          pr;
        int            out;
        bit            train;
        int            w0, w1, w16;
    } vec_t;

    vec_t vt[9];
    int   exp_upd, exp_skip, w0c, r0c, lat, c, base, bad;

    initial begin
        vt[0] = '{6'd5,  16'hFFFF, 1'b1, 1'b0,    0, 1'b1,  1,  1,  1};
        vt[1] = '{6'd10, 16'h0001, 1'b0, 1'b1,    0, 1'b1, -1, -1,  1};
        vt[2] = '{6'd11, 16'h8000, 1'b1, 1'b1,  100, 1'b0,  0,  0,  0};
        vt[3] = '{6'd12, 16'h8000, 1'b1, 1'b1,  -44, 1'b1,  1, -1,  1};
        vt[4] = '{6'd13, 16'h0000, 1'b0, 1'b0,   45, 1'b0,  0,  0,  0};
        vt[5] = '{6'd14, 16'h0000, 1'b0, 1'b0,  -45, 1'b0,  0,  0,  0};
        vt[6] = '{6'd15, 16'h5555, 1'b0, 1'b0,   44, 1'b1, -1, -1,  1};
        vt[7] = '{6'd16, 16'h0000, 1'b1, 1'b1,    0, 1'b1,  1, -1, -1};
        vt[8] = '{6'd17, 16'hFFFF, 1'b0, 1'b1, -100, 1'b1, -1, -1, -1};

        clk = 1'b0; rst = 1'b1; req_valid = 1'b0; req_index = '0; req_history = '0;
        req_outcome = 1'b0; req_prediction = 1'b0; req_output = '0; lookup_req = 1'b0;
        pl_en = 1'b0; pl_clr = 1'b1; pl_addr = '0; pl_data = '0;
        exp_upd = 0; exp_skip = 0;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_ready", req_ready, 1);
        check("rst_upd_cnt", update_count, 0);
        check("rst_skip_cnt", skip_count, 0);
        pl_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            w0c = wr_cnt; r0c = rd_cnt;
            send(vt[i].idx, vt[i].hist, vt[i].oc, vt[i].pr, vt[i].out);
            if (vt[i].train) begin
                exp_upd++;
                wait_done(0, lat);
                check("latency", lat, 52);
                @(negedge clk);
                check("done_one_cycle", done, 0);
            end else begin
                exp_skip++;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    check("skip_busy", busy, 0);
                end
            end
            check("writes", wr_cnt - w0c, vt[i].train ? 17 : 0);
            check("reads", rd_cnt - r0c, vt[i].train ? 17 : 0);
            check("w0", mem[wa(vt[i].idx, 0)], vt[i].w0);
            check("w1", mem[wa(vt[i].idx, 1)], vt[i].w1);
            check("w16", mem[wa(vt[i].idx, 16)], vt[i].w16);
            check("upd_cnt", update_count, exp_upd);
            check("skip_cnt", skip_count, exp_skip);
        end

        bad = 0;
        for (int k = 0; k < 17; k++) if (mem[wa(5, k)] !== 8'sd1) bad++;
        check("p5_all_plus1", bad, 0);

        // Saturation at both rails.
        preload(wa(20, 0), 127);
        preload(wa(20, 5), 126);
        preload(wa(21, 0), -128);
        preload(wa(21, 5), -127);
        w0c = wr_cnt;
        send(6'd20, 16'hFFFF, 1'b1, 1'b0, 0);
        wait_done(0, lat);
        exp_upd++;
        check("sat_hi_w0", mem[wa(20, 0)], 127);
        check("sat_hi_w5", mem[wa(20, 5)], 127);
        check("sat_hi_w1", mem[wa(20, 1)], 1);
        check("sat_hi_writes", wr_cnt - w0c, 17);
        send(6'd21, 16'hFFFF, 1'b0, 1'b1, 0);
        wait_done(0, lat);
        exp_upd++;
        check("sat_lo_w0", mem[wa(21, 0)], -128);
        check("sat_lo_w5", mem[wa(21, 5)], -128);
        check("sat_lo_w1", mem[wa(21, 1)], -1);

        // FIFO fill while the scheduler is busy, then in-order drain.
        base = order_q.size();
        send(6'd29, 16'hFFFF, 1'b1, 1'b0, 0);
        push(6'd30, 1'b1);
        push(6'd31, 1'b0);
        push(6'd32, 1'b1);
        push(6'd33, 1'b0);
        check("fifo_full_ready", req_ready, 0);
        check("fifo_busy", busy, 1);
        push(6'd34, 1'b1);
        req_valid = 1'b0;
        exp_upd += 6;
        c = 0;
        while (update_count != 16'(exp_upd) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("fifo_upd_cnt", update_count, exp_upd);
        check("fifo_order_len", order_q.size() - base, 6);
        for (int j = 0; j < 6; j++) begin
            if (base + j < order_q.size()) check("fifo_order", order_q[base + j], 29 + j);
        end
        check("fifo_w30", mem[wa(30, 0)], 1);
        check("fifo_w31", mem[wa(31, 0)], -1);
        check("fifo_w34", mem[wa(34, 0)], 1);

        // Lookup contention: three stalled cycles in RD.
        w0c = wr_cnt; r0c = rd_cnt;
        send(6'd40, 16'hFFFF, 1'b1, 1'b0, 0);
        @(negedge clk);
        lookup_req = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            check("stall_rd_en", mem_rd_en, 0);
            check("stall_busy", busy, 1);
            @(negedge clk);
        end
        lookup_req = 1'b0;
        check("stall_no_reads", rd_cnt - r0c, 0);
        wait_done(4, lat);
        exp_upd++;
        check("stall_latency", lat, 55);
        check("stall_writes", wr_cnt - w0c, 17);
        bad = 0;
        for (int k = 0; k < 17; k++) if (mem[wa(40, k)] !== 8'sd1) bad++;
        check("stall_weights", bad, 0);

        // Reset in the middle of an update, with another request queued.
        send(6'd50, 16'hFFFF, 1'b1, 1'b0, 0);
        send(6'd51, 16'hFFFF, 1'b1, 1'b0, 0);
        c = 0;
        while (!(mem_rd_en && mem_addr == AW'(wa(50, 8))) && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("reach_k8", c < 200, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_en", mem_rd_en, 0);
        check("mid_rst_wr_en", mem_wr_en, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_upd", update_count, 0);
        check("mid_rst_skip", skip_count, 0);
        w0c = wr_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("post_rst_writes", wr_cnt - w0c, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_upd", update_count, 0);
        bad = 0;
        for (int k = 0; k < 8; k++) if (mem[wa(50, k)] !== 8'sd1) bad++;
        check("rst_kept_0_7", bad, 0);
        bad = 0;
        for (int k = 8; k < 17; k++) if (mem[wa(50, k)] !== 8'sd0) bad++;
        check("rst_untouched_8_16", bad, 0);
        check("rst_fifo_flushed", mem[wa(51, 0)], 0);

        check("bus_protocol", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perceptron_update_sched.md
PERCEPTRON_UPDATE_SCHED -- requirements
Module: perceptron_update_sched

Interface
REQ-001 SHALL have parameter PERCEPTRON_NUMBER, default 64, number of perceptrons (power of two).
REQ-002 SHALL have parameter HISTORY_SIZE, default 16, global history bits. WEIGHT_NUMBER is fixed at HISTORY_SIZE+1, with index 0 as the bias.
REQ-003 SHALL have parameter WIDTH, default 8, signed weight width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, number of pending training requests (power of two).
REQ-005 SHALL have parameter THRESHOLD, default 44, the training threshold (floor(1.93*HISTORY_SIZE+14)).
REQ-006 SHALL have ports: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-007 SHALL have ports: req_valid in 1, a resolved branch offered for training; req_ready out 1, asserted as !fifo_full.
REQ-008 SHALL have ports: req_index in log2(PERCEPTRON_NUMBER), the perceptron; req_history in HISTORY_SIZE, the history used at prediction.
REQ-009 SHALL have ports: req_outcome in 1, where 1 means taken; req_prediction in 1; req_output in signed WIDTH+log2(WEIGHT_NUMBER)+1, the perceptron sum.
REQ-010 SHALL have port lookup_req in 1, the predictor lookup claiming the weight port this cycle (highest priority).
REQ-011 SHALL have ports: mem_rd_en out 1; mem_wr_en out 1; mem_addr out log2(PERCEPTRON_NUMBER)+log2(WEIGHT_NUMBER), formed as {perceptron,k}.
REQ-012 SHALL have ports: mem_wdata out signed WIDTH; mem_rdata in signed WIDTH, valid the cycle after mem_rd_en.
REQ-013 SHALL have ports: busy out 1; done out 1, a one-cycle pulse; update_count out 16; skip_count out 16.

Function
REQ-014 SHALL accept a request only when req_valid && req_ready.
REQ-015 SHALL, for an accepted request, enqueue it only if req_prediction!=req_outcome or |req_output|<=THRESHOLD. Otherwise it SHALL drop the request and increment skip_count (wrapping).
REQ-016 SHALL hold queued requests in a FIFO of FIFO_DEPTH entries, in arrival order. fifo_full is count==FIFO_DEPTH. An enqueue and a pop in the same cycle SHALL leave count unchanged.
REQ-017 SHALL implement FSM states IDLE, RD, CAP, WR.
REQ-018 IDLE: if the FIFO is non-empty, the block SHALL pop the head into working registers, set k=0, and go to RD. IDLE SHALL make no memory access.
REQ-019 RD: if lookup_req=1, the block SHALL stay in RD with no access. Otherwise it SHALL assert mem_rd_en with addr {p,k} and go to CAP.
REQ-020 CAP: the block SHALL latch mem_rdata into the weight register, compute the new weight, and go to WR, regardless of lookup_req.
REQ-021 WR: if lookup_req=1, the block SHALL hold with no access. Otherwise it SHALL assert mem_wr_en with addr {p,k} and the new weight.
REQ-022 WR (continued): if k<WEIGHT_NUMBER-1, the block SHALL increment k and go to RD. If k=WEIGHT_NUMBER-1, it SHALL pulse done, increment update_count (wrapping), and go to IDLE.
REQ-023 SHALL compute the update as new = sat(w + t*x):
- t = +1 if outcome is taken, else -1.
- x = +1 for k=0.
- For k>=1, x = +1 if history[k-1]=1, else -1.
REQ-024 sat SHALL clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. A weight already at the limit SHALL be rewritten unchanged.
REQ-025 SHALL take 1+3*WEIGHT_NUMBER cycles per request with no lookup contention (52 at defaults). Each lookup_req cycle in RD or WR adds one cycle.
REQ-026 SHALL never assert mem_rd_en or mem_wr_en while lookup_req=1, and never both in the same cycle.
REQ-027 SHALL assert busy in RD, CAP and WR.
REQ-028 SHALL not pop a new request in the cycle done pulses. That pop occurs in the following IDLE cycle.

Reset
REQ-029 SHALL, on rst=1, asynchronously:
- force IDLE;
- empty the FIFO;
- clear k and the working registers;
- clear update_count and skip_count.
REQ-030 SHALL hold all of busy, done, mem_rd_en, mem_wr_en, mem_addr and mem_wdata at 0 during reset. req_ready SHALL be 1 during reset.
REQ-031 A reset asserted mid-update SHALL abandon it with no further memory write. Weights already written SHALL remain.

Verification
REQ-032 Mispredict, index 5, history 0xFFFF, outcome taken, all weights 0 -> weights 0..16 of perceptron 5 become +1; done pulses 52 cycles after accept; update_count=1.
REQ-033 Correct prediction with req_output=100 -> skip_count=1, no mem access, busy stays 0. Repeat with req_output=-44 -> one update performed.
REQ-034 Weight at 127, outcome taken, x=+1 -> 127 rewritten. Weight at -128, outcome not-taken, x=+1 -> -128 rewritten.
REQ-035 Five back-to-back training requests with FIFO_DEPTH=4 and the scheduler busy -> req_ready deasserts after the 4th is queued. All queued requests are processed in order.
REQ-036 lookup_req held 3 cycles during RD -> no mem_rd_en during those cycles; total latency becomes 55 cycles; final weights match the uncontended run.
REQ-037 rst pulsed at k=8 -> no write after reset; weights 0..7 updated, 8..16 unchanged; FIFO empty; counters 0.
